// File: rtl/cmp_arbiter.sv
// Round-robin arbiter in front of one shared equality comparator.
// Each grant takes three cycles: grant/latch, compare, respond.
module cmp_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_REQ = 4
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [N_REQ-1:0]       REQ,
   input  logic [N_REQ*WIDTH-1:0] DATA_A,
   input  logic [N_REQ*WIDTH-1:0] DATA_B,
   output logic [N_REQ-1:0]       GNT,
   output logic [N_REQ-1:0]       RESP_VALID,
   output logic                   RESP_EQUAL,
   output logic                   BUSY,
   output logic                   CMP_ENABLE,
   output logic [WIDTH-1:0]       CMP_DATA_IN_1,
   output logic [WIDTH-1:0]       CMP_DATA_IN_2,
   input  logic [WIDTH-1:0]       CMP_EQUAL,
   output logic [15:0]            MATCH_CNT
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StCompare, StRespond} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d;
   logic [WIDTH-1:0]  op_b_q, op_b_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic              resp_equal_q, resp_equal_d;
   logic [15:0]       match_cnt_q, match_cnt_d;

   logic              win_found;
   logic [IdxW-1:0]   win_idx;
   logic [WIDTH-1:0]  sel_a, sel_b;

   // First set REQ bit at or after ptr_q, wrapping past N_REQ-1.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = (int'(ptr_q) + k) % N_REQ;
         if (!win_found && REQ[cand]) begin
            win_found = 1'b1;
            win_idx   = IdxW'(cand);
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_idx == IdxW'(i)) begin
            sel_a = DATA_A[i*WIDTH +: WIDTH];
            sel_b = DATA_B[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      idx_d        = idx_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      gnt_d        = '0;
      resp_equal_d = resp_equal_q;
      match_cnt_d  = match_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d = StCompare;
               idx_d   = win_idx;
               op_a_d  = sel_a;
               op_b_d  = sel_b;
               gnt_d   = N_REQ'(1) << win_idx;
               ptr_d   = (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + IdxW'(1);
            end
         end
         StCompare: begin
            state_d      = StRespond;
            resp_equal_d = |CMP_EQUAL;
            if (|CMP_EQUAL && match_cnt_q != 16'hFFFF) begin
               match_cnt_d = match_cnt_q + 16'd1;
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         idx_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         gnt_q        <= '0;
         resp_equal_q <= 1'b0;
         match_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         gnt_q        <= gnt_d;
         resp_equal_q <= resp_equal_d;
         match_cnt_q  <= match_cnt_d;
      end
   end

   assign GNT           = gnt_q;
   assign RESP_VALID    = (state_q == StRespond) ? (N_REQ'(1) << idx_q) : '0;
   assign RESP_EQUAL    = resp_equal_q;
   assign BUSY          = (state_q != StIdle);
   assign CMP_ENABLE    = (state_q == StCompare);
   assign CMP_DATA_IN_1 = op_a_q;
   assign CMP_DATA_IN_2 = op_b_q;
   assign MATCH_CNT     = match_cnt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin/compare model.
module tb_cmp_arbiter;

   localparam int W = 32;
   localparam int N = 4;

   logic             CLK;
   logic             RST_N;
   logic [N-1:0]     REQ;
   logic [N*W-1:0]   DATA_A, DATA_B;
   logic [N-1:0]     GNT, RESP_VALID;
   logic             RESP_EQUAL, BUSY, CMP_ENABLE;
   logic [W-1:0]     CMP_DATA_IN_1, CMP_DATA_IN_2, CMP_EQUAL;
   logic [15:0]      MATCH_CNT;
   logic [W-1:0]     eq_pat;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int m_ptr = 0;
   int m_cnt = 0;
   bit m_eq  = 0;

   cmp_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DATA_A(DATA_A), .DATA_B(DATA_B),
      .GNT(GNT), .RESP_VALID(RESP_VALID), .RESP_EQUAL(RESP_EQUAL), .BUSY(BUSY),
      .CMP_ENABLE(CMP_ENABLE), .CMP_DATA_IN_1(CMP_DATA_IN_1),
      .CMP_DATA_IN_2(CMP_DATA_IN_2), .CMP_EQUAL(CMP_EQUAL), .MATCH_CNT(MATCH_CNT)
   );

   // External comparator: any nonzero pattern signals equality.
   assign CMP_EQUAL = (CMP_DATA_IN_1 == CMP_DATA_IN_2) ? eq_pat : '0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic model_reset();
      m_ptr = 0;
      m_cnt = 0;
      m_eq  = 0;
   endtask

   task automatic do_reset();
      REQ = '0;
      RST_N = 1'b0;
      #2;
      model_reset();
      RST_N = 1'b1;
   endtask

   task automatic run_op(input logic [N-1:0] req, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input bit chg, input logic [N-1:0] req2,
                         input logic [N*W-1:0] a2, input logic [N*W-1:0] b2, input string nm);
      int w;
      bit e;
      logic [W-1:0] wa, wb;
      logic [N-1:0] oh;
      REQ = req;
      DATA_A = a;
      DATA_B = b;
      eq_pat = W'(1) << $urandom_range(W - 1, 0);
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      @(posedge CLK); #1;
      if (w < 0) begin
         n_cmp++;
         if (BUSY !== 1'b0 || GNT !== '0) begin
            n_bad++;
            $display("FAIL %s idle: busy=%b gnt=%b, want busy=0 gnt=0", nm, BUSY, GNT);
         end
         return;
      end
      wa = a[w*W +: W];
      wb = b[w*W +: W];
      oh = N'(1) << w;
      m_ptr = (w + 1) % N;
      e = (wa == wb);
      if (e && m_cnt < 65535) m_cnt++;
      n_cmp++;
      if (GNT !== oh) begin
         n_bad++; $display("FAIL %s gnt: got %b want %b", nm, GNT, oh);
      end
      n_cmp++;
      if ({BUSY, CMP_ENABLE, RESP_VALID} !== {1'b1, 1'b1, {N{1'b0}}}) begin
         n_bad++;
         $display("FAIL %s compare_state: busy=%b en=%b rv=%b want 1 1 0", nm, BUSY,
                  CMP_ENABLE, RESP_VALID);
      end
      n_cmp++;
      if (CMP_DATA_IN_1 !== wa || CMP_DATA_IN_2 !== wb) begin
         n_bad++;
         $display("FAIL %s operands: got %h/%h want %h/%h", nm, CMP_DATA_IN_1, CMP_DATA_IN_2,
                  wa, wb);
      end
      if (chg) begin
         REQ = req2;
         DATA_A = a2;
         DATA_B = b2;
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (RESP_VALID !== oh || GNT !== '0 || CMP_ENABLE !== 1'b0 || BUSY !== 1'b1) begin
         n_bad++;
         $display("FAIL %s respond: rv=%b gnt=%b en=%b busy=%b want rv=%b gnt=0 en=0 busy=1",
                  nm, RESP_VALID, GNT, CMP_ENABLE, BUSY, oh);
      end
      n_cmp++;
      if (RESP_EQUAL !== e) begin
         n_bad++; $display("FAIL %s resp_equal: got %b want %b", nm, RESP_EQUAL, e);
      end
      n_cmp++;
      if (MATCH_CNT !== 16'(m_cnt)) begin
         n_bad++; $display("FAIL %s match_cnt: got %0d want %0d", nm, MATCH_CNT, m_cnt);
      end
      m_eq = e;
      @(posedge CLK); #1;
      n_cmp++;
      if (BUSY !== 1'b0 || RESP_VALID !== '0 || RESP_EQUAL !== m_eq || CMP_DATA_IN_1 !== wa) begin
         n_bad++;
         $display("FAIL %s back_idle: busy=%b rv=%b eq=%b op1=%h want 0 0 %b %h", nm, BUSY,
                  RESP_VALID, RESP_EQUAL, CMP_DATA_IN_1, m_eq, wa);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b1;
      REQ = '0;
      DATA_A = '0;
      DATA_B = '0;
      eq_pat = 32'h1;
      #2 RST_N = 1'b0;
      #1;
      n_cmp++;
      if ({GNT, RESP_VALID, RESP_EQUAL, BUSY, CMP_ENABLE} !== '0 || MATCH_CNT !== 16'd0 ||
          CMP_DATA_IN_1 !== '0 || CMP_DATA_IN_2 !== '0) begin
         n_bad++;
         $display("FAIL reset: gnt=%b rv=%b eq=%b busy=%b en=%b cnt=%0d op=%h/%h want all 0",
                  GNT, RESP_VALID, RESP_EQUAL, BUSY, CMP_ENABLE, MATCH_CNT, CMP_DATA_IN_1,
                  CMP_DATA_IN_2);
      end
      @(posedge CLK); @(posedge CLK); #1;
      model_reset();
      RST_N = 1'b1;
   endtask

   task automatic test_single();
      logic [N*W-1:0] a, b;
      a = '0; b = '0;
      a[1*W +: W] = 256;
      b[1*W +: W] = 256;
      run_op(4'b0010, a, b, 0, '0, '0, '0, "single");
   endtask

   task automatic test_mismatch();
      logic [N*W-1:0] a, b;
      a = '0; b = '0;
      a[0 +: W] = 100;
      b[0 +: W] = 4;
      run_op(4'b0001, a, b, 0, '0, '0, '0, "mismatch");
   endtask

   task automatic test_fairness();
      logic [N*W-1:0] a, b;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom, $urandom, $urandom};
         b = (i % 2 == 0) ? a : ~a;
         run_op(4'b1111, a, b, 0, '0, '0, '0, "fairness");
      end
   endtask

   task automatic test_wrap();
      logic [N*W-1:0] a;
      do_reset();
      a = {$urandom, $urandom, $urandom, $urandom};
      run_op(4'b0100, a, a, 0, '0, '0, '0, "wrap_setup");
      run_op(4'b1001, a, ~a, 0, '0, '0, '0, "wrap_first");
      run_op(4'b1001, a, a, 0, '0, '0, '0, "wrap_second");
   endtask

   task automatic test_reset_midop();
      logic [N*W-1:0] a;
      a = {$urandom, $urandom, $urandom, $urandom};
      REQ = 4'b0100;
      DATA_A = a;
      DATA_B = a;
      @(posedge CLK); #1;
      RST_N = 1'b0;
      #1;
      n_cmp++;
      if ({GNT, RESP_VALID, BUSY, CMP_ENABLE, RESP_EQUAL} !== '0 || MATCH_CNT !== 16'd0 ||
          CMP_DATA_IN_1 !== '0) begin
         n_bad++;
         $display("FAIL reset_midop: gnt=%b rv=%b busy=%b en=%b eq=%b cnt=%0d op1=%h want 0",
                  GNT, RESP_VALID, BUSY, CMP_ENABLE, RESP_EQUAL, MATCH_CNT, CMP_DATA_IN_1);
      end
      model_reset();
      REQ = '0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      n_cmp++;
      if (RESP_VALID !== '0 || BUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_midop_after: rv=%b busy=%b want 0 0", RESP_VALID, BUSY);
      end
      run_op(4'b1110, a, a, 0, '0, '0, '0, "reset_regrant");
   endtask

   task automatic test_operand_change();
      logic [N*W-1:0] a, b, a2;
      a = '0; b = '0;
      b[0 +: W] = 256;
      a2 = a;
      a2[0 +: W] = 256;
      run_op(4'b0001, a, b, 1, 4'b0001, a2, b, "operand_change");
   endtask

   task automatic test_random();
      logic [N*W-1:0] a, b, a2, b2;
      logic [N-1:0] r, r2;
      for (int i = 0; i < 60; i++) begin
         for (int j = 0; j < N; j++) begin
            a[j*W +: W] = ($urandom_range(3, 0) == 0) ? W'($urandom_range(3, 0)) : $urandom;
            b[j*W +: W] = ($urandom_range(1, 0) == 0) ? a[j*W +: W] : $urandom;
         end
         a2 = {$urandom, $urandom, $urandom, $urandom};
         b2 = ($urandom_range(1, 0) == 0) ? a2 : ~a2;
         r  = N'($urandom_range(15, 0));
         r2 = N'($urandom_range(15, 0));
         run_op(r, a, b, 1'($urandom_range(1, 0)), r2, a2, b2, "random");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mismatch();
      test_fairness();
      test_wrap();
      test_reset_midop();
      test_operand_change();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
